// File: rtl/sum_arbiter.sv
// sum_arbiter
//   Shares one WIDTH-bit modular adder among NUM_REQ requesters. A round-robin
//   arbiter grants one operand pair at a time, registers a+b (carry discarded)
//   and returns it on a per-requester response handshake.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester operand-pair valid
//   req_ready   per-requester accept strobe (one-hot or zero, combinational)
//   req_a/req_b packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid  per-requester result valid (one-hot or zero, registered)
//   resp_ready  per-requester result taken
//   resp_sum    registered sum, qualified by resp_valid
//   busy        high while a result is outstanding
//   op_count    completed response handshakes, wraps modulo 2^16
module sum_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]           resp_sum,
  output logic                       busy,
  output logic [15:0]                op_count
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [15:0]          op_count_q, op_count_d;

  // Round-robin search result
  logic                 found;
  logic [PW-1:0]        win;

  // Scan req_valid starting at ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = PW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and outputs
  always_comb begin
    int unsigned base;
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    sum_d        = sum_q;
    resp_valid_d = resp_valid_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    base         = 32'(win) * WIDTH;

    case (state_q)
      IDLE: begin
        // Gated by rst_n so no accept strobe is shown while held in reset.
        if (found && rst_n) begin
          req_ready[win]    = 1'b1;
          sum_d             = req_a[base +: WIDTH] + req_b[base +: WIDTH];
          gnt_d             = win;
          state_d           = RESP;
          resp_valid_d      = '0;
          resp_valid_d[win] = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready[gnt_q]) begin
          state_d      = IDLE;
          resp_valid_d = '0;
          ptr_d        = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          op_count_d   = op_count_q + 16'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      sum_q        <= '0;
      resp_valid_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      sum_q        <= sum_d;
      resp_valid_q <= resp_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = sum_q;
  assign busy       = (state_q == RESP);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_sum_arbiter.sv
module tb_sum_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready;
  logic [W-1:0]     resp_sum;
  logic             busy;
  logic [15:0]      op_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned  idx;
    logic [W-1:0] sum;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] cnt_m;

  sum_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  // Drive requester r alone (in IDLE), expect it to be granted, push result.
  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N-1:0] exp_rdy;
    exp_t e;
    exp_rdy    = '0;
    exp_rdy[r] = 1'b1;
    set_op(r, a, b);
    req_valid[r] = 1'b1;
    #1;
    check("req_ready", req_ready, exp_rdy);
    e.idx = r;
    e.sum = a + b;
    sbq.push_back(e);
    tick();
    req_valid[r] = 1'b0;
  endtask

  // Pop expected result, hold resp_ready low for 'hold' cycles, then handshake.
  task automatic complete(input int hold);
    exp_t e;
    logic [N-1:0] exp_v;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%0h expected=nonempty", resp_valid);
      return;
    end
    e = sbq.pop_front();
    exp_v = '0;
    exp_v[e.idx] = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", resp_valid, exp_v);
      check("resp_sum", resp_sum, e.sum);
      check("busy_resp", busy, 1'b1);
      check("ready_in_resp", req_ready, '0);
      if (h < hold) tick();
    end
    resp_ready[e.idx] = 1'b1;
    tick();
    resp_ready = '0;
    cnt_m = cnt_m + 16'd1;
    check("op_count", op_count, cnt_m);
    check("busy_idle", busy, 1'b0);
    check("resp_valid_idle", resp_valid, '0);
  endtask

  initial begin
    logic [N-1:0] onehot;
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    cnt_m      = '0;

    // Reset state, with all requesters valid
    #1;
    check("rst_resp_valid", resp_valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", resp_sum, '0);
    check("rst_op_count", op_count, '0);
    check("rst_req_ready", req_ready, '0);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single op
    issue(1, 32'h0000_0005, 32'h0000_0007);
    complete(0);

    // Modular wrap
    issue(2, 32'hFFFF_FFFF, 32'h0000_0002);
    complete(0);
    issue(3, 32'h8000_0000, 32'h8000_0000);
    complete(0);

    // Round-robin: pointer now 0, everyone valid, responses taken at once
    for (int r = 0; r < N; r++) set_op(r, 32'(r * 16 + 1), 32'(r + 100));
    req_valid  = '1;
    resp_ready = '1;
    for (int i = 0; i < 5; i++) begin
      int r;
      r = i % N;
      onehot = '0;
      onehot[r] = 1'b1;
      #1;
      check("rr_grant", req_ready, onehot);
      tick();
      check("rr_resp_valid", resp_valid, onehot);
      check("rr_resp_sum", resp_sum, 32'(r * 16 + 1) + 32'(r + 100));
      tick();
      cnt_m = cnt_m + 16'd1;
    end
    check("rr_op_count", op_count, cnt_m);
    req_valid  = '0;
    resp_ready = '0;
    tick();

    // Backpressure with a competing requester and a spurious resp_ready
    issue(2, 32'h1234_0000, 32'h0000_5678);
    set_op(0, 32'h0000_00AA, 32'h0000_0055);
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b1;
    #1;
    complete(5);
    issue(0, 32'h0000_00AA, 32'h0000_0055);
    complete(0);

    // Reset while a result is outstanding
    issue(1, 32'h0000_0100, 32'h0000_0200);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", resp_valid, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sum", resp_sum, '0);
    check("mid_rst_op_count", op_count, '0);
    sbq.delete();
    cnt_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(3, 32'h0000_0010, 32'h0000_0020);
    complete(0);

    // Counter wrap: preload close to the top, then finish two operations
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    cnt_m = 16'hFFFE;
    issue(0, 32'h0000_0001, 32'h0000_0001);
    complete(0);
    issue(1, 32'h0000_0002, 32'h0000_0002);
    complete(0);
    check("op_count_wrapped", op_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_arbiter.md
# sum_arbiter

Time-shares one 32-bit modular adder (`a + b`, carry discarded) among `NUM_REQ` independent requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter grants one request at a time, registers the sum, and returns it over a per-requester response handshake. The block sits between several client engines and the single shared sum datapath, so clients never contend for the adder directly.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: operand and sum width.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i has an operand pair.
- `req_ready`  out  NUM_REQ  bit i: request i accepted this cycle (one-hot or zero).
- `req_a`  in  NUM_REQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand b; same slicing.
- `resp_valid`  out  NUM_REQ  bit i: result for requester i is valid (one-hot or zero).
- `resp_ready`  in  NUM_REQ  bit i: requester i takes its result.
- `resp_sum`  out  WIDTH  registered sum; shared bus, qualified by `resp_valid`.
- `busy`  out  1  high whenever state is RESP.
- `op_count`  out  16  number of completed response handshakes, wraps modulo 2^16.

## Operation
- States: IDLE, RESP. `ptr` is the round-robin pointer, width clog2(NUM_REQ). `gnt` is the registered grant index.
- IDLE:
  - Arbitration scans `req_valid` from index `ptr` upward, wrapping past NUM_REQ-1 to 0. The first set bit g wins.
  - `req_ready[g]`=1 combinationally; all other bits 0. If no `req_valid` bit is set, `req_ready`=0 and the block stays in IDLE.
  - On accept (`req_valid[g]` & `req_ready[g]`): `resp_sum` <= (a_g + b_g) mod 2^WIDTH, `gnt` <= g, state <= RESP.
- RESP:
  - `resp_valid[gnt]`=1; `req_ready`=0 for all requesters. `resp_sum` is held stable.
  - On `resp_ready[gnt]`: state <= IDLE, `ptr` <= (gnt+1) mod NUM_REQ, `op_count` <= `op_count`+1.
  - `resp_ready` bits other than `gnt` are ignored.
- No back-to-back accept in the same cycle as the response handshake. A new grant is issued only in IDLE.
- Requester rules: `req_a`/`req_b` must stay stable while `req_valid` is high and before accept. The block does not check this.
- Arithmetic: unsigned, carry out of bit WIDTH-1 is discarded (0xFFFFFFFF + 1 = 0).
- Reset (`rst_n` low, any time): state=IDLE, `ptr`=0, `gnt`=0, `resp_sum`=0, `resp_valid`=0, `busy`=0, `op_count`=0, `req_ready`=0. An in-flight transaction is dropped with no response.
- `op_count` wraps from 0xFFFF to 0x0000 with no flag.

## Timing
- `req_ready` is combinational from `req_valid`, state and `ptr` (no combinational path from operands).
- `resp_valid`, `resp_sum` and `busy` are registered outputs.
- Latency: request accepted on edge T, so `resp_valid` is high in cycle T+1.
- Minimum issue interval per op is 2 cycles (accept, then response with immediate `resp_ready`). Peak throughput is 1 op per 2 cycles.
- Response backpressure of k cycles extends RESP by k cycles. All other requesters stall for that time.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 other completed operations.
- Reset deassertion: first accept is possible in the first cycle with `rst_n` high.

## Test plan
- Single op: requester 1 sends a=0x00000005, b=0x00000007 -> `req_ready`=0b0010 in that cycle; next cycle `resp_valid`=0b0010 with `resp_sum`=0x0000000C; `op_count`=1 after `resp_ready[1]`.
- Wrap-around: a=0xFFFFFFFF, b=0x00000002 -> `resp_sum`=0x00000001; a=0x80000000, b=0x80000000 -> `resp_sum`=0.
- Round-robin: all 4 `req_valid` held high with `resp_ready` tied high -> grant order 0,1,2,3,0 on accepts at cycles 0,2,4,6,8; `ptr` returns to 0 after the 4th.
- Backpressure: requester 2 granted, `resp_ready[2]` held low 5 cycles while requester 0 is valid -> `resp_valid`=0b0100 and `resp_sum` stable for 6 cycles, `req_ready`=0 throughout; requester 0 is granted the cycle after the handshake; a spurious `resp_ready[0]` during RESP has no effect.
- Reset mid-op: assert `rst_n` low while in RESP -> `resp_valid`, `busy`, `resp_sum` and `op_count` go to 0 immediately (asynchronously); after release, requester 3 alone valid is accepted in the first cycle.
- Counter wrap: force 65536 completions -> `op_count` reads 0x0000 after the last handshake.
